im_ram: RTL and testbench
=========================

Name: im_ram

Overview:
- Parametrised successor to the fixed-program instruction memory.
- Writable, registered instruction store for the 16-bit pipelined CPU. Sits between the PC stage and the IF/ID register.
- After reset, a self-initialising sweep fills every entry with HALT. Programs can then be loaded word-by-word through a loader port.
- Fetch has one-cycle read latency, with stall-hold and flush-bubble support for the pipeline.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 8, fetch/program address width.
- DEPTH, 256, number of stored words; must be ≤ 2**ADDR_W.
- FILL_WORD, {`HALT, 11'd0}, value written by the init sweep and returned for out-of-range addresses.
- NOP_WORD, 16'h0000, bubble word driven on flush and while not in RUN.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  fetch address from PC.
- fetch_en  in  1  request a fetch this cycle.
- stall  in  1  hold iout/iout_valid unchanged.
- flush  in  1  replace the next output with a bubble.
- iout  out  DATA_W  registered instruction.
- iout_valid  out  1  iout holds a real fetched word.
- ready  out  1  high only in RUN.
- prog_mode  in  1  request LOAD mode.
- prog_we  in  1  loader write strobe.
- prog_addr  in  ADDR_W  loader write address.
- prog_data  in  DATA_W  loader write data.
- prog_count  out  ADDR_W+1  number of accepted writes since entering LOAD.
- prog_err  out  1  sticky: out-of-range write attempted.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=INIT, sweep pointer=0.
  - iout=NOP_WORD, iout_valid=0, ready=0, prog_count=0, prog_err=0.
  - Memory contents are not reset directly; the sweep handles initialisation.
- INIT:
  - Each cycle writes FILL_WORD at the sweep pointer, then increments it.
  - After writing entry DEPTH-1 → RUN. INIT lasts exactly DEPTH cycles after reset release.
  - fetch_en, prog_mode and prog_we are ignored.
- RUN:
  - ready=1.
  - Priority order, evaluated every cycle:
    - stall=1 → iout and iout_valid hold. Stall beats flush and fetch.
    - flush=1 → iout=NOP_WORD, iout_valid=0.
    - fetch_en=1 → next cycle iout=mem[addr], iout_valid=1. Latency is exactly 1 clock.
    - Otherwise iout_valid=0 and iout holds.
  - addr ≥ DEPTH returns FILL_WORD with iout_valid=1.
  - prog_mode=1 with stall=0 → LOAD next cycle; iout=NOP_WORD, iout_valid=0.
  - prog_mode=1 with stall=1 → wait in RUN until stall drops.
- LOAD:
  - ready=0, fetch_en ignored, iout=NOP_WORD, iout_valid=0.
  - prog_count clears to 0 on entry.
  - prog_we=1 with prog_addr < DEPTH → mem[prog_addr]=prog_data; prog_count increments, saturating at 2**ADDR_W.
  - prog_we=1 with prog_addr ≥ DEPTH → no write, prog_err=1.
  - prog_mode=0 → RUN next cycle.
  - prog_err clears only on reset.
- A write issued in the same cycle that prog_mode falls is still performed.
- Reset mid-INIT or mid-LOAD aborts immediately and restarts the sweep. Partially loaded programs are lost.
- Fetch of an address written the previous cycle returns the new data. No read/write collision is possible, because fetch and write are mutually exclusive by state.

Decomposition:
- Shared package/define file:
  - opcode constants (`HALT and others).
  - state encoding: IM_INIT=2'd0, IM_RUN=2'd1, IM_LOAD=2'd2.
  - default NOP/FILL words.
- One natural sub-module, im_ram_array:
  - single-port synchronous RAM, DEPTH×DATA_W.
  - one write port and a registered read port.
  - the top level muxes sweep, loader and fetch onto it.

Test Plan:
- Reset release, DEPTH=256 → ready rises on cycle 256. Fetch addr=0x05 → next cycle iout={`HALT,11'd0}, iout_valid=1.
- LOAD: write 0x1234@0x00 and 0xBEEF@0x10, drop prog_mode, fetch 0x10 → iout=0xBEEF one cycle later; prog_count=2.
- DEPTH=200: LOAD write to 0xC8 → no write, prog_err=1. RUN fetch 0xC8 → FILL_WORD, iout_valid=1.
- RUN fetch 0x00 → iout=0x1234. Then stall=1 for 3 cycles with addr changing → iout stays 0x1234, valid stays 1. Then flush=1 → iout=0x0000, iout_valid=0.
- Assert reset mid-LOAD after 1 write → ready=0, prog_count=0. After the sweep, fetch 0x00 → FILL_WORD; the loaded word is gone.
- prog_mode and stall asserted together → stays in RUN, ready=1 until stall drops; LOAD is entered the next cycle.

Source files
------------

// File: rtl/im_ram_pkg.sv
// Shared constants for the instruction store: opcodes, FSM encoding and the
// default fill/bubble words.
package im_ram_pkg;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_LD   = 5'h08;
   localparam logic [4:0] OP_ST   = 5'h09;
   localparam logic [4:0] OP_BEQ  = 5'h10;
   localparam logic [4:0] OP_JMP  = 5'h11;
   localparam logic [4:0] OP_HALT = 5'h1F;

   typedef enum logic [1:0] {
      IM_INIT = 2'd0,
      IM_RUN  = 2'd1,
      IM_LOAD = 2'd2
   } im_state_e;

   localparam logic [15:0] IM_FILL_WORD = {OP_HALT, 11'd0};
   localparam logic [15:0] IM_NOP_WORD  = 16'h0000;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/im_ram_if.sv
// Fetch and loader bus between the CPU front end and the instruction store.
interface im_ram_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8
) ();

   logic [ADDR_W-1:0] addr;
   logic              fetch_en;
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] iout;
   logic              iout_valid;
   logic              ready;
   logic              prog_mode;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [ADDR_W:0]   prog_count;
   logic              prog_err;

   modport master (
      output addr, fetch_en, stall, flush, prog_mode, prog_we, prog_addr, prog_data,
      input  iout, iout_valid, ready, prog_count, prog_err
   );

   modport slave (
      input  addr, fetch_en, stall, flush, prog_mode, prog_we, prog_addr, prog_data,
      output iout, iout_valid, ready, prog_count, prog_err
   );

endinterface

// File: rtl/im_ram_array.sv
// Single-port DEPTH x DATA_W store with a registered read port; the read
// register can also be loaded directly so it doubles as the fetch output flop.
module im_ram_array #(
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       DEPTH      = 256,
   parameter int unsigned       IDX_W      = 8,
   parameter logic [DATA_W-1:0] RESET_WORD = {DATA_W{1'b0}}
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic              rd_en,
   input  logic              ovr_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] ovr_data,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Storage write; contents are initialised by the owner's sweep, not by reset
   always_ff @(posedge clock) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   // Next read-register value: direct load beats a memory read, else hold
   always_comb begin
      rdata_d = rdata_q;
      if (ovr_en) begin
         rdata_d = ovr_data;
      end else if (rd_en) begin
         rdata_d = mem[idx];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Read register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= RESET_WORD;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/im_ram.sv
// Writable instruction store: HALT-fill sweep after reset, word loader in LOAD
// mode, one-cycle fetch with stall-hold and flush-bubble in RUN mode.
module im_ram
   import im_ram_pkg::*;
#(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 8,
   parameter int unsigned       DEPTH     = 256,
   parameter logic [DATA_W-1:0] FILL_WORD = IM_FILL_WORD,
   parameter logic [DATA_W-1:0] NOP_WORD  = IM_NOP_WORD
) (
   input logic     clock,
   input logic     reset,
   im_ram_if.slave bus
);

   localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W    = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

   im_state_e         state_q, state_d;
   logic [IDX_W-1:0]  sweep_q, sweep_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              mem_we, rd_en, ovr_en;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_wdata, ovr_data, iout_s;
   logic              fetch_ok, prog_ok;

   assign fetch_ok = addr_in_range(32'(bus.addr), DEPTH);
   assign prog_ok  = addr_in_range(32'(bus.prog_addr), DEPTH);

   // Next-state, output and RAM port steering for all three modes
   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      valid_d   = valid_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_idx   = bus.addr[IDX_W-1:0];
      mem_wdata = bus.prog_data;
      rd_en     = 1'b0;
      ovr_en    = 1'b0;
      ovr_data  = NOP_WORD;
      case (state_q)
         IM_INIT: begin
            mem_we    = 1'b1;
            mem_idx   = sweep_q;
            mem_wdata = FILL_WORD;
            ovr_en    = 1'b1;
            valid_d   = 1'b0;
            if (sweep_q == LAST_IDX) begin
               state_d = IM_RUN;
               sweep_d = {IDX_W{1'b0}};
            end else begin
               sweep_d = sweep_q + IDX_W'(1);
            end
         end
         IM_RUN: begin
            // A stalled pipeline freezes everything, including a pending LOAD request
            if (bus.stall) begin
               valid_d = valid_q;
            end else if (bus.prog_mode) begin
               state_d = IM_LOAD;
               ovr_en  = 1'b1;
               valid_d = 1'b0;
               cnt_d   = {CNT_W{1'b0}};
            end else if (bus.flush) begin
               ovr_en  = 1'b1;
               valid_d = 1'b0;
            end else if (bus.fetch_en) begin
               valid_d = 1'b1;
               if (fetch_ok) begin
                  rd_en = 1'b1;
               end else begin
                  ovr_en   = 1'b1;
                  ovr_data = FILL_WORD;
               end
            end else begin
               valid_d = 1'b0;
            end
         end
         IM_LOAD: begin
            ovr_en  = 1'b1;
            valid_d = 1'b0;
            mem_idx = bus.prog_addr[IDX_W-1:0];
            if (bus.prog_we) begin
               if (prog_ok) begin
                  mem_we = 1'b1;
                  cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               mem_we = 1'b0;
            end
            if (!bus.prog_mode) begin
               state_d = IM_RUN;
            end else begin
               state_d = IM_LOAD;
            end
         end
         default: begin
            state_d = IM_INIT;
            sweep_d = {IDX_W{1'b0}};
            ovr_en  = 1'b1;
            valid_d = 1'b0;
         end
      endcase
      ready_d = (state_d == IM_RUN);
   end

   // Control state and registered status outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IM_INIT;
         sweep_q <= {IDX_W{1'b0}};
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   im_ram_array #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W),
      .RESET_WORD (NOP_WORD)
   ) u_array (
      .clock    (clock),
      .reset    (reset),
      .we       (mem_we),
      .rd_en    (rd_en),
      .ovr_en   (ovr_en),
      .idx      (mem_idx),
      .wdata    (mem_wdata),
      .ovr_data (ovr_data),
      .rdata    (iout_s)
   );

   assign bus.iout       = iout_s;
   assign bus.iout_valid = valid_q;
   assign bus.ready      = ready_q;
   assign bus.prog_count = cnt_q;
   assign bus.prog_err   = err_q;

endmodule

// File: tb/tb_im_ram.sv
// Bench for im_ram: two instances (DEPTH 256 and 200) share one stimulus
// stream and are compared against a memory-array reference model.
module tb_im_ram;
   import im_ram_pkg::*;

   localparam logic [15:0] FILL = {OP_HALT, 11'd0};
   localparam logic [15:0] NOP  = 16'h0000;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [7:0]  addr, prog_addr;
   logic [15:0] prog_data;
   logic        fetch_en, stall, flush, prog_mode, prog_we;

   im_ram_if #(.DATA_W(16), .ADDR_W(8)) if_a ();
   im_ram_if #(.DATA_W(16), .ADDR_W(8)) if_b ();

   im_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
   im_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

   assign if_a.addr = addr;           assign if_b.addr = addr;
   assign if_a.fetch_en = fetch_en;   assign if_b.fetch_en = fetch_en;
   assign if_a.stall = stall;         assign if_b.stall = stall;
   assign if_a.flush = flush;         assign if_b.flush = flush;
   assign if_a.prog_mode = prog_mode; assign if_b.prog_mode = prog_mode;
   assign if_a.prog_we = prog_we;     assign if_b.prog_we = prog_we;
   assign if_a.prog_addr = prog_addr; assign if_b.prog_addr = prog_addr;
   assign if_a.prog_data = prog_data; assign if_b.prog_data = prog_data;

   logic [15:0] iout_o [2];
   logic        valid_o [2];
   logic        ready_o [2];
   logic        err_o [2];
   logic [8:0]  cnt_o [2];
   assign iout_o[0] = if_a.iout;        assign iout_o[1] = if_b.iout;
   assign valid_o[0] = if_a.iout_valid; assign valid_o[1] = if_b.iout_valid;
   assign ready_o[0] = if_a.ready;      assign ready_o[1] = if_b.ready;
   assign err_o[0] = if_a.prog_err;     assign err_o[1] = if_b.prog_err;
   assign cnt_o[0] = if_a.prog_count;   assign cnt_o[1] = if_b.prog_count;

   // Reference model: per-instance memory image, depth, sticky error, write count
   int          depth_m [2] = '{256, 200};
   logic [15:0] mem_m [2][256];
   logic        err_m [2];
   int          cnt_m [2];
   logic [15:0] exp_iout [2];
   logic        exp_valid [2];

   int checks = 0;
   int errors = 0;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      addr = 8'h00; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
      prog_mode = 1'b0; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
   endtask

   task automatic model_fill();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mem_m[d][i] = FILL;
         err_m[d] = 1'b0;
         cnt_m[d] = 0;
      end
   endtask

   function automatic logic [15:0] model_read(input int d, input int a);
      return (a < depth_m[d]) ? mem_m[d][a] : FILL;
   endfunction

   task automatic sweep_wait(output int first_a, output int first_b);
      first_a = -1;
      first_b = -1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (ready_o[0] && first_a < 0) first_a = k;
         if (ready_o[1] && first_b < 0) first_b = k;
      end
   endtask

   task automatic test_reset();
      int fa, fb;
      idle();
      reset = 1'b0;
      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== NOP || valid_o[d] !== 1'b0 || ready_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out[%0d] got iout=%h valid=%b ready=%b want %h 0 0", d, iout_o[d], valid_o[d], ready_o[d], NOP);
         end
         checks++;
         if (cnt_o[d] !== 9'd0 || err_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_prog[%0d] got count=%0d err=%b want 0 0", d, cnt_o[d], err_o[d]);
         end
      end
      reset = 1'b1;
      sweep_wait(fa, fb);
      checks++;
      if (fa != 256) begin
         errors++;
         $display("FAIL init_len[0] ready after %0d cycles want 256", fa);
      end
      checks++;
      if (fb != 200) begin
         errors++;
         $display("FAIL init_len[1] ready after %0d cycles want 200", fb);
      end
      model_fill();
   endtask

   task automatic test_fetch_fill();
      addr = 8'h05; fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== FILL || valid_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_fill[%0d] got %h/%b want %h/1", d, iout_o[d], valid_o[d], FILL);
         end
      end
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== FILL || valid_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold[%0d] got %h/%b want %h/0", d, iout_o[d], valid_o[d], FILL);
         end
      end
   endtask

   task automatic test_load_basic();
      idle();
      prog_mode = 1'b1;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ready_o[d] !== 1'b0 || valid_o[d] !== 1'b0 || iout_o[d] !== NOP || cnt_o[d] !== 9'd0) begin
            errors++;
            $display("FAIL load_entry[%0d] got ready=%b valid=%b iout=%h count=%0d want 0 0 %h 0", d, ready_o[d], valid_o[d], iout_o[d], cnt_o[d], NOP);
         end
      end
      prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'h1234;
      step();
      // last write lands in the same cycle that prog_mode drops
      prog_addr = 8'h10; prog_data = 16'hBEEF; prog_mode = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         mem_m[d][0] = 16'h1234;
         mem_m[d][16] = 16'hBEEF;
      end
      prog_we = 1'b0; addr = 8'h10; fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== model_read(d, 16) || valid_o[d] !== 1'b1 || ready_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL load_fetch[%0d] got %h/%b ready=%b want %h/1 ready=1", d, iout_o[d], valid_o[d], ready_o[d], model_read(d, 16));
         end
         checks++;
         if (cnt_o[d] !== 9'd2) begin
            errors++;
            $display("FAIL load_count[%0d] got %0d want 2", d, cnt_o[d]);
         end
      end
   endtask

   task automatic test_range();
      logic [15:0] e;
      idle();
      prog_mode = 1'b1;
      step();
      prog_we = 1'b1; prog_addr = 8'hC8; prog_data = 16'hAAAA;
      step();
      prog_addr = 8'hC7; prog_data = 16'h5555;
      step();
      prog_we = 1'b0; prog_mode = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         cnt_m[d] = 0;
         if (200 < depth_m[d]) begin mem_m[d][200] = 16'hAAAA; cnt_m[d]++; end
         else err_m[d] = 1'b1;
         mem_m[d][199] = 16'h5555; cnt_m[d]++;
         checks++;
         if (cnt_o[d] !== 9'(cnt_m[d]) || err_o[d] !== err_m[d]) begin
            errors++;
            $display("FAIL range_prog[%0d] got count=%0d err=%b want %0d %b", d, cnt_o[d], err_o[d], cnt_m[d], err_m[d]);
         end
      end
      for (int a = 200; a >= 199; a--) begin
         addr = 8'(a); fetch_en = 1'b1;
         step();
         for (int d = 0; d < 2; d++) begin
            e = model_read(d, a);
            checks++;
            if (iout_o[d] !== e || valid_o[d] !== 1'b1) begin
               errors++;
               $display("FAIL range_fetch[%0d] addr=%h got %h/%b want %h/1", d, a, iout_o[d], valid_o[d], e);
            end
         end
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_stall_flush();
      idle();
      addr = 8'h00; fetch_en = 1'b1;
      step();
      for (int c = 0; c < 3; c++) begin
         stall = 1'b1; addr = 8'(c + 1); flush = (c == 1);
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (iout_o[d] !== 16'h1234 || valid_o[d] !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold[%0d] cyc=%0d got %h/%b want 1234/1", d, c, iout_o[d], valid_o[d]);
            end
         end
      end
      stall = 1'b0; flush = 1'b1;
      step();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== NOP || valid_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL flush[%0d] got %h/%b want %h/0", d, iout_o[d], valid_o[d], NOP);
         end
      end
   endtask

   task automatic test_mode_stall();
      idle();
      stall = 1'b1; prog_mode = 1'b1; fetch_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         addr = 8'($urandom_range(0, 255));
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready_o[d] !== 1'b1) begin
               errors++;
               $display("FAIL mode_stall_ready[%0d] cyc=%0d got %b want 1", d, c, ready_o[d]);
            end
         end
      end
      stall = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ready_o[d] !== 1'b0 || valid_o[d] !== 1'b0 || iout_o[d] !== NOP) begin
            errors++;
            $display("FAIL mode_enter[%0d] got ready=%b %h/%b want 0 %h/0", d, ready_o[d], iout_o[d], valid_o[d], NOP);
         end
      end
      prog_mode = 1'b0; fetch_en = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ready_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL mode_exit[%0d] got ready=%b want 1", d, ready_o[d]);
         end
      end
   endtask

   task automatic test_random();
      idle();
      prog_mode = 1'b1;
      step();
      for (int d = 0; d < 2; d++) cnt_m[d] = 0;
      for (int w = 0; w < 24; w++) begin
         prog_we = ($urandom_range(0, 3) != 0);
         prog_addr = 8'($urandom_range(0, 255));
         prog_data = 16'($urandom);
         for (int d = 0; d < 2; d++) begin
            if (prog_we) begin
               if (int'(prog_addr) < depth_m[d]) begin
                  mem_m[d][prog_addr] = prog_data;
                  if (cnt_m[d] < 256) cnt_m[d]++;
               end else begin
                  err_m[d] = 1'b1;
               end
            end
         end
         step();
      end
      prog_we = 1'b0; prog_mode = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (cnt_o[d] !== 9'(cnt_m[d]) || err_o[d] !== err_m[d]) begin
            errors++;
            $display("FAIL rand_prog[%0d] got count=%0d err=%b want %0d %b", d, cnt_o[d], err_o[d], cnt_m[d], err_m[d]);
         end
         exp_iout[d] = NOP;
         exp_valid[d] = 1'b0;
      end
      for (int c = 0; c < 60; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 4) == 0);
         fetch_en = ($urandom_range(0, 3) != 0);
         addr = 8'($urandom_range(0, 255));
         for (int d = 0; d < 2; d++) begin
            if (stall) begin
               exp_valid[d] = exp_valid[d];
            end else if (flush) begin
               exp_iout[d] = NOP; exp_valid[d] = 1'b0;
            end else if (fetch_en) begin
               exp_iout[d] = model_read(d, int'(addr)); exp_valid[d] = 1'b1;
            end else begin
               exp_valid[d] = 1'b0;
            end
         end
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (iout_o[d] !== exp_iout[d] || valid_o[d] !== exp_valid[d] || ready_o[d] !== 1'b1) begin
               errors++;
               $display("FAIL rand_fetch[%0d] cyc=%0d got %h/%b ready=%b want %h/%b ready=1", d, c, iout_o[d], valid_o[d], ready_o[d], exp_iout[d], exp_valid[d]);
            end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_load();
      int fa, fb;
      idle();
      prog_mode = 1'b1;
      step();
      prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'h7777;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (cnt_o[d] !== 9'd1) begin
            errors++;
            $display("FAIL mid_load_count[%0d] got %0d want 1", d, cnt_o[d]);
         end
      end
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ready_o[d] !== 1'b0 || cnt_o[d] !== 9'd0 || err_o[d] !== 1'b0 || valid_o[d] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset[%0d] got ready=%b count=%0d err=%b valid=%b want 0 0 0 0", d, ready_o[d], cnt_o[d], err_o[d], valid_o[d]);
         end
      end
      idle();
      step();
      reset = 1'b1;
      model_fill();
      sweep_wait(fa, fb);
      checks++;
      if (fa != 256 || fb != 200) begin
         errors++;
         $display("FAIL reinit_len got %0d/%0d want 256/200", fa, fb);
      end
      addr = 8'h00; fetch_en = 1'b1;
      step();
      fetch_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (iout_o[d] !== model_read(d, 0) || valid_o[d] !== 1'b1) begin
            errors++;
            $display("FAIL lost_program[%0d] got %h/%b want %h/1", d, iout_o[d], valid_o[d], model_read(d, 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_fill();
      test_load_basic();
      test_range();
      test_stall_flush();
      test_mode_stall();
      test_random();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
